// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: full-frame VGA raster timing with run/idle control on frame boundaries.
// Optional feature macro VGA_FRAME_CNT_EN adds o_frame, an 8-bit count of completed frames.
module vga_timing_ctrl #(
   parameter int H_VIDEO = 640,
   parameter int H_FRONT = 16,
   parameter int H_PULSE = 96,
   parameter int H_BACK  = 48,
   parameter int V_VIDEO = 480,
   parameter int V_FRONT = 10,
   parameter int V_PULSE = 2,
   parameter int V_BACK  = 33
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic       i_enable,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic       o_de,
   output logic [9:0] o_x,
   output logic [9:0] o_y,
   output logic       o_line_start,
   output logic       o_frame_start,
   output logic       o_busy
`ifdef VGA_FRAME_CNT_EN
   ,output logic [7:0] o_frame
`endif
);

   localparam int H_TOTAL = H_VIDEO + H_FRONT + H_PULSE + H_BACK;
   localparam int V_TOTAL = V_VIDEO + V_FRONT + V_PULSE + V_BACK;

   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   // 11-bit bounds so a window ending exactly at 1024 still compares correctly
   localparam logic [10:0] H_ACT    = 11'(H_VIDEO);
   localparam logic [10:0] HS_START = 11'(H_VIDEO + H_FRONT);
   localparam logic [10:0] HS_END   = 11'(H_VIDEO + H_FRONT + H_PULSE);
   localparam logic [10:0] V_ACT    = 11'(V_VIDEO);
   localparam logic [10:0] VS_START = 11'(V_VIDEO + V_FRONT);
   localparam logic [10:0] VS_END   = 11'(V_VIDEO + V_FRONT + V_PULSE);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [9:0]  r_col;
   logic [9:0]  r_row;
   logic        w_run;
   logic        w_col_last;
   logic        w_row_last;
   logic        w_eof;
   logic [10:0] w_col_x;
   logic [10:0] w_row_x;

   assign w_run      = (r_state == ST_RUN);
   assign w_col_last = (r_col == H_LAST);
   assign w_row_last = (r_row == V_LAST);
   assign w_eof      = w_run && w_col_last && w_row_last;
   assign w_col_x    = {1'b0, r_col};
   assign w_row_x    = {1'b0, r_row};

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= ST_IDLE;
      else            r_state <= w_next;
   end

   // i_enable only matters in IDLE and on the last pixel of a frame
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (i_enable) w_next = ST_RUN;
         ST_RUN:  if (w_eof && !i_enable) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (!w_run) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_col_last) begin
         r_col <= '0;
         r_row <= w_row_last ? 10'd0 : r_row + 10'd1;
      end else begin
         r_col <= r_col + 10'd1;
      end
   end

   // Every output decodes from r_state and the counters, so all describe the same pixel
   always_comb begin
      o_hsync       = 1'b1;
      o_vsync       = 1'b1;
      o_de          = 1'b0;
      o_line_start  = 1'b0;
      o_frame_start = 1'b0;
      o_busy        = w_run;
      o_x           = r_col;
      o_y           = r_row;
      if (w_run) begin
         o_hsync       = !((w_col_x >= HS_START) && (w_col_x < HS_END));
         o_vsync       = !((w_row_x >= VS_START) && (w_row_x < VS_END));
         o_de          = (w_col_x < H_ACT) && (w_row_x < V_ACT);
         o_line_start  = (r_col == 10'd0);
         o_frame_start = (r_col == 10'd0) && (r_row == 10'd0);
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] r_frame;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n)  r_frame <= '0;
      else if (w_eof)  r_frame <= r_frame + 8'd1;
   end

   assign o_frame = r_frame;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Table-driven bench for vga_timing_ctrl on a shrunken 15x11 raster (frame = 165 cycles).
module tb_vga_timing_ctrl;

   localparam int HV = 8, HF = 2, HP = 3, HB = 2;
   localparam int VV = 6, VF = 2, VP = 2, VB = 1;
   localparam int HT = HV + HF + HP + HB;
   localparam int VT = VV + VF + VP + VB;
   localparam int FRAME = HT * VT;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       hs, vs, de, ls, fs, busy;
   logic [9:0] x, y;
`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frame;
`endif

   int n_vec = 0;
   int n_err = 0;

   vga_timing_ctrl #(
      .H_VIDEO(HV), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
      .V_VIDEO(VV), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB)
   ) dut (
      .i_clock      (clk),
      .i_reset_n    (rst_n),
      .i_enable     (en),
      .o_hsync      (hs),
      .o_vsync      (vs),
      .o_de         (de),
      .o_x          (x),
      .o_y          (y),
      .o_line_start (ls),
      .o_frame_start(fs),
      .o_busy       (busy)
`ifdef VGA_FRAME_CNT_EN
      ,.o_frame     (frame)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       en;
      int         cycles;
      logic [9:0] x;
      logic [9:0] y;
      logic       hs, vs, de, ls, fs, busy;
   } vec_t;

   vec_t vecs[24];

   function automatic vec_t mk(input logic e, input int c, input int vx, input int vy,
                               input logic h, input logic v, input logic d,
                               input logic l, input logic f, input logic b);
      vec_t r;
      r.en = e; r.cycles = c; r.x = 10'(vx); r.y = 10'(vy);
      r.hs = h; r.vs = v; r.de = d; r.ls = l; r.fs = f; r.busy = b;
      return r;
   endfunction

   function automatic logic [31:0] pack_out();
      return {6'd0, hs, vs, de, ls, fs, busy, x, y};
   endfunction

   function automatic logic [31:0] pack_vec(input vec_t v);
      return {6'd0, v.hs, v.vs, v.de, v.ls, v.fs, v.busy, v.x, v.y};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   localparam logic [31:0] IDLE_OUT = {6'd0, 6'b110000, 10'd0, 10'd0};

   initial begin
      int ex, ey, bad, n_de, n_hs, n_vs, n_ls, n_fs, vs_first_x, vs_first_y;

      // {en, cycles, x, y, hs, vs, de, line_start, frame_start, busy}
      vecs[0]  = mk(0, 0,   0,  0, 1, 1, 0, 0, 0, 0);
      vecs[1]  = mk(0, 20,  0,  0, 1, 1, 0, 0, 0, 0);
      vecs[2]  = mk(1, 1,   0,  0, 1, 1, 1, 1, 1, 1);
      vecs[3]  = mk(1, 1,   1,  0, 1, 1, 1, 0, 0, 1);
      vecs[4]  = mk(1, 6,   7,  0, 1, 1, 1, 0, 0, 1);
      vecs[5]  = mk(1, 1,   8,  0, 1, 1, 0, 0, 0, 1);
      vecs[6]  = mk(1, 2,  10,  0, 0, 1, 0, 0, 0, 1);
      vecs[7]  = mk(1, 2,  12,  0, 0, 1, 0, 0, 0, 1);
      vecs[8]  = mk(1, 1,  13,  0, 1, 1, 0, 0, 0, 1);
      vecs[9]  = mk(1, 1,  14,  0, 1, 1, 0, 0, 0, 1);
      vecs[10] = mk(1, 1,   0,  1, 1, 1, 1, 1, 0, 1);
      vecs[11] = mk(0, 105, 0,  8, 1, 0, 0, 1, 0, 1);
      vecs[12] = mk(0, 15,  0,  9, 1, 0, 0, 1, 0, 1);
      vecs[13] = mk(0, 15,  0, 10, 1, 1, 0, 1, 0, 1);
      vecs[14] = mk(0, 14, 14, 10, 1, 1, 0, 0, 0, 1);
      vecs[15] = mk(0, 1,   0,  0, 1, 1, 0, 0, 0, 0);
      vecs[16] = mk(0, 30,  0,  0, 1, 1, 0, 0, 0, 0);
      vecs[17] = mk(1, 1,   0,  0, 1, 1, 1, 1, 1, 1);
      vecs[18] = mk(1, 164,14, 10, 1, 1, 0, 0, 0, 1);
      vecs[19] = mk(1, 1,   0,  0, 1, 1, 1, 1, 1, 1);
      vecs[20] = mk(0, 50,  5,  3, 1, 1, 1, 0, 0, 1);
      vecs[21] = mk(1, 1,   6,  3, 1, 1, 1, 0, 0, 1);
      vecs[22] = mk(0, 113,14, 10, 1, 1, 0, 0, 0, 1);
      vecs[23] = mk(0, 1,   0,  0, 1, 1, 0, 0, 0, 0);

      rst_n = 1'b0;
      en    = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;

      for (int i = 0; i < 24; i++) begin
         en = vecs[i].en;
         repeat (vecs[i].cycles) step();
         check($sformatf("vec%0d", i), pack_out(), pack_vec(vecs[i]));
      end

`ifdef VGA_FRAME_CNT_EN
      check("frame_cnt_after_3", {24'd0, frame}, 32'd3);
`endif

      // Long idle stretch: outputs must stay at idle values every cycle
      en  = 1'b0;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (pack_out() !== IDLE_OUT) bad++;
      end
      check("idle_hold", 32'(bad), 32'd0);
`ifdef VGA_FRAME_CNT_EN
      check("frame_cnt_idle_hold", {24'd0, frame}, 32'd3);
`endif

      // Walk one full frame against an independent position model
      en = 1'b1;
      step();
      check("walk_start", pack_out(), {6'd0, 6'b111111, 10'd0, 10'd0});
      ex = 0; ey = 0; bad = 0;
      n_de = 0; n_hs = 0; n_vs = 0; n_ls = 0; n_fs = 0;
      vs_first_x = -1; vs_first_y = -1;
      for (int i = 0; i < FRAME; i++) begin
         logic eh, ev, ed, el, ef;
         step();
         if (ex == HT - 1) begin
            ex = 0;
            ey = (ey == VT - 1) ? 0 : ey + 1;
         end else begin
            ex = ex + 1;
         end
         eh = !(ex >= HV + HF && ex < HV + HF + HP);
         ev = !(ey >= VV + VF && ey < VV + VF + VP);
         ed = (ex < HV) && (ey < VV);
         el = (ex == 0);
         ef = (ex == 0) && (ey == 0);
         if (pack_out() !== {6'd0, eh, ev, ed, el, ef, 1'b1, 10'(ex), 10'(ey)}) bad++;
         if (de) n_de++;
         if (!hs) n_hs++;
         if (!vs) begin
            n_vs++;
            if (vs_first_x < 0) begin
               vs_first_x = int'(x);
               vs_first_y = int'(y);
            end
         end
         if (ls) n_ls++;
         if (fs) n_fs++;
      end
      check("walk_model", 32'(bad), 32'd0);
      check("de_per_frame", 32'(n_de), 32'(HV * VV));
      check("hs_low_per_frame", 32'(n_hs), 32'(HP * VT));
      check("vs_low_per_frame", 32'(n_vs), 32'(VP * HT));
      check("vs_first_pos", 32'({vs_first_x[15:0], vs_first_y[15:0]}), {16'd0, 16'(VV + VF)});
      check("line_starts", 32'(n_ls), 32'(VT));
      check("frame_starts", 32'(n_fs), 32'd1);

      // Asynchronous reset mid-frame at (7,4), then restart with enable held
      repeat (67) step();
      check("pre_reset_pos", {12'd0, x, y}, {12'd0, 10'd7, 10'd4});
      #2 rst_n = 1'b0;
      #1;
      check("async_reset", pack_out(), IDLE_OUT);
      step();
      check("reset_held", pack_out(), IDLE_OUT);
      #2 rst_n = 1'b1;
      step();
      check("restart_after_reset", pack_out(), {6'd0, 6'b111111, 10'd0, 10'd0});
      step();
      check("restart_advance", {12'd0, x, y}, {12'd0, 10'd1, 10'd0});

`ifdef VGA_FRAME_CNT_EN
      // 256 consecutive frames from reset wrap the counter back to 0
      #2 rst_n = 1'b0;
      #1;
      check("frame_cnt_reset", {24'd0, frame}, 32'd0);
      #2 rst_n = 1'b1;
      en = 1'b1;
      step();
      repeat (256 * FRAME - 1) step();
      check("frame_cnt_255", {8'd0, frame, 6'd0, busy, 9'd0},
            {8'd255, 8'd0, 6'd0, 1'b1, 9'd0});
      en = 1'b0;
      step();
      check("frame_cnt_wrap", {24'd0, frame}, 32'd0);
      check("stop_after_256", pack_out(), IDLE_OUT);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute time limit so the bench always terminates
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Full-frame VGA timing controller that sequences the horizontal sync generator into a complete 2-D raster. It runs a column counter and a row counter and drives hsync, vsync, data-enable and pixel coordinates for the pixel pipeline. A run/idle state machine starts and stops the raster cleanly on frame boundaries.

## Interface
Parameters:
- H_VIDEO, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_PULSE, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VIDEO, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_PULSE, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- i_clock  input  1  pixel clock
- i_reset_n  input  1  asynchronous, active-low reset
- i_enable  input  1  request raster output; sampled every cycle
- o_hsync  output  1  horizontal sync, active low
- o_vsync  output  1  vertical sync, active low
- o_de  output  1  active-video data enable
- o_x  output  10  current column
- o_y  output  10  current row
- o_line_start  output  1  one-cycle pulse at column 0 of every line
- o_frame_start  output  1  one-cycle pulse at pixel (0,0)
- o_busy  output  1  high while in RUN

## Operation
- H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525). Both must be ≤ 1024; counters are fixed at 10 bits.
- States: IDLE, RUN. Reset enters IDLE.
- IDLE: col = row = 0 held; o_hsync = o_vsync = 1, o_de = 0, o_line_start = o_frame_start = 0, o_busy = 0, o_x = o_y = 0.
- IDLE -> RUN: i_enable sampled high. The next cycle shows pixel (0,0).
- RUN: col increments each cycle. At col = H_TOTAL-1, col wraps to 0 and row increments. At row = V_TOTAL-1, row wraps to 0.
- End of frame is col = H_TOTAL-1, row = V_TOTAL-1. There, i_enable = 1 wraps to (0,0) and stays in RUN; i_enable = 0 goes to IDLE.
- i_enable is ignored mid-frame: deasserting it never truncates a frame, and reasserting it before end of frame continues without a gap.
- Decodes, valid in RUN only:
  - o_hsync = 0 when H_VIDEO+H_FRONT ≤ col < H_VIDEO+H_FRONT+H_PULSE (656..751).
  - o_vsync = 0 when V_VIDEO+V_FRONT ≤ row < V_VIDEO+V_FRONT+V_PULSE (490..491), for whole lines.
  - o_de = 1 when col < H_VIDEO and row < V_VIDEO.
  - o_x = col, o_y = row.
  - o_line_start = (col == 0); o_frame_start = (col == 0 && row == 0).

## Timing
- All outputs are decoded only from registered state and counters; there is no combinational path from i_enable to any output.
- All outputs describe the same pixel in the same cycle (zero skew between o_x/o_y and o_de/o_hsync/o_vsync).
- Start latency: i_enable sampled high at edge N in IDLE gives (0,0) with o_frame_start = 1 after edge N+1.
- Stop: the cycle after (H_TOTAL-1, V_TOTAL-1) with i_enable = 0 shows IDLE values and o_busy = 0.
- Reset asserted at any time forces the IDLE output values immediately, without waiting for a clock. After release, the block waits in IDLE for i_enable.

## Configuration
- VGA_FRAME_CNT_EN defined: adds port o_frame (output, 8 bits), a count of completed frames.
  - Reset value 0.
  - Increments at every end-of-frame cycle, whether the next state is RUN or IDLE.
  - Wraps 255 -> 0.
  - Holds its value in IDLE.
- VGA_FRAME_CNT_EN undefined: port o_frame and its logic are absent; all other behaviour is identical.

## Test plan
- Reset, then i_enable = 0 for 2000 cycles -> o_hsync = 1, o_vsync = 1, o_de = 0, o_busy = 0 throughout.
- i_enable rises at cycle N -> at N+1: o_x = 0, o_y = 0, o_frame_start = 1, o_de = 1. Horizontal timing:
  - o_hsync low for exactly 96 cycles starting at o_x = 656.
  - Line period is 800 cycles.
  - o_line_start period is 800 cycles.
- Free-run one frame -> o_vsync low for 1600 consecutive cycles starting at (0,490). Frame period is 420000 cycles, and o_de is high for 307200 cycles per frame.
- Drop i_enable at (0,100) -> the frame completes to (799,524), o_busy falls on the next cycle, and no further o_frame_start occurs. A pulse of i_enable at (5,300) that drops again before end of frame gives the same result.
- Assert i_reset_n = 0 at (300,200) -> outputs take IDLE values without a clock edge. Release with i_enable = 1 -> the raster restarts at (0,0) after 1 cycle.
- VGA_FRAME_CNT_EN defined, run 3 frames then stop -> o_frame = 3 and holds in IDLE. Run 256 frames from reset -> o_frame = 0.
